// File: rtl/rf_wb_arbiter_if.sv
// Aux writer handshake channel into the register-file write-back arbiter.
interface rf_wb_arbiter_if;
   logic        aux_valid;
   logic [4:0]  aux_addr;
   logic [31:0] aux_data;
   logic        aux_ready;

   modport master (
      output aux_valid,
      output aux_addr,
      output aux_data,
      input  aux_ready
   );

   modport slave (
      input  aux_valid,
      input  aux_addr,
      input  aux_data,
      output aux_ready
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: the W-stage pipeline write has absolute priority, and aux results
// queue in order behind it. Also reports queued-register hits and aux starvation.
module rf_wb_arbiter #(
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  w_we,
   input  logic [4:0]            w_addr,
   input  logic [31:0]           w_data,
   rf_wb_arbiter_if.slave        aux,
   input  logic [4:0]            q_a1,
   input  logic [4:0]            q_a2,
   output logic                  busy_a1,
   output logic                  busy_a2,
   output logic                  stall_req,
   output logic                  rf_we,
   output logic [4:0]            rf_a3,
   output logic [31:0]           rf_wd
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   logic [4:0]       addr_q [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [PW-1:0]    head_q, tail_q;
   logic [CW-1:0]    cnt_q;
   logic [SW-1:0]    starve_q, starve_d;

   logic pw, full, push, pop, head_ok, any_writable;

   always_comb begin
      pw       = w_we && (w_addr != 5'd0);
      full     = (cnt_q == CW'(DEPTH));
      push     = aux.aux_valid && !full;
      // Valid bits are only ever set on occupied slots, so vld alone implies occupancy.
      head_ok  = vld_q[head_q] && (addr_q[head_q] != 5'd0) && !reset;
      // A writable head waits behind the pipeline; anything else at the head leaves at the edge.
      pop      = (cnt_q != '0) && !(pw && head_ok);
      aux.aux_ready = !full;

      any_writable = 1'b0;
      busy_a1      = 1'b0;
      busy_a2      = 1'b0;
      vld_d        = vld_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && (addr_q[i] != 5'd0)) any_writable = 1'b1;
         if (vld_q[i] && (q_a1 != 5'd0) && (addr_q[i] == q_a1)) busy_a1 = 1'b1;
         if (vld_q[i] && (q_a2 != 5'd0) && (addr_q[i] == q_a2)) busy_a2 = 1'b1;
         // Pipeline value is newer than anything already queued for the same register.
         if (pw && vld_q[i] && (addr_q[i] == w_addr)) vld_d[i] = 1'b0;
      end
      if (pop)  vld_d[head_q] = 1'b0;
      if (push) vld_d[tail_q] = 1'b1;

      starve_d = starve_q;
      if ((head_ok && !pw) || !any_writable) begin
         starve_d = '0;
      end else if (head_ok && pw && (starve_q != SW'(STARVE_LIMIT))) begin
         starve_d = starve_q + SW'(1);
      end
      stall_req = (starve_q == SW'(STARVE_LIMIT));

      rf_we = 1'b0;
      rf_a3 = 5'd0;
      rf_wd = 32'd0;
      if (pw) begin
         rf_we = 1'b1;
         rf_a3 = w_addr;
         rf_wd = w_data;
      end else if (head_ok) begin
         rf_we = 1'b1;
         rf_a3 = addr_q[head_q];
         rf_wd = data_q[head_q];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q    <= '0;
         head_q   <= '0;
         tail_q   <= '0;
         cnt_q    <= '0;
         starve_q <= '0;
      end else begin
         vld_q    <= vld_d;
         starve_q <= starve_d;
         cnt_q    <= cnt_q + CW'(push) - CW'(pop);
         if (pop) head_q <= head_q + PW'(1);
         if (push) begin
            addr_q[tail_q] <= aux.aux_addr;
            data_q[tail_q] <= aux.aux_data;
            tail_q         <= tail_q + PW'(1);
         end
      end
   end

endmodule
